// File: rtl/u74hc_pkg.sv
// Shared constants for the 74HC-family models: default and maximum output delay.
// Optional U74HC165_SERIAL_MONITOR_EN adds q_par to u74hc165_piso; nothing here depends on it.
package u74hc_pkg;

  localparam int DEFAULT_DELAY = 9;
  localparam int MAX_DELAY     = 32;

  // Out-of-range delays are pulled into 1..MAX_DELAY so the delay line always has stages.
  function automatic int clamp_delay(input int delay);
    if (delay < 1)
      return 1;
    else if (delay > MAX_DELAY)
      return MAX_DELAY;
    else
      return delay;
  endfunction

endpackage

// File: rtl/hc_delay_line.sv
// Fixed-latency shift line modelling output propagation delay, in clk cycles.
// Independent of U74HC165_SERIAL_MONITOR_EN.
module hc_delay_line
  import u74hc_pkg::*;
#(
  parameter int   DELAY = DEFAULT_DELAY,
  parameter logic INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int STAGES = clamp_delay(DELAY);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {STAGES{INIT}};
    end else begin
      stages[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[STAGES-1];

endmodule

// File: rtl/u74hc165_piso.sv
// Cycle-based model of a 74HC165 8-bit parallel-in/serial-out shift register.
// Define U74HC165_SERIAL_MONITOR_EN to expose the undelayed register contents on q_par.
module u74hc165_piso
  import u74hc_pkg::*;
#(
  parameter logic [7:0] IC    = 8'h00,
  parameter int         DELAY = DEFAULT_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vcc,
  input  logic       gnd,
  input  logic       pl_n,
  input  logic       cp,
  input  logic       ce_n,
  input  logic       ds,
  input  logic [7:0] d,
`ifdef U74HC165_SERIAL_MONITOR_EN
  output logic [7:0] q_par,
`endif
  output logic       q7,
  output logic       q7_n
);

  logic       vrst;
  logic       cpe;
  logic       cpe_q;
  logic       shift_edge;
  logic [7:0] shift_reg;
  logic       q7_dly;
  logic       unused_gnd;

  // Losing supply behaves exactly like holding reset.
  assign vrst       = rst | ~vcc;
  assign cpe        = cp | ce_n;
  assign shift_edge = ~cpe_q & cpe;
  assign unused_gnd = gnd;

  // cpe_q resets high so a fresh low-then-high on the chip clock is needed after reset.
  always_ff @(posedge clk) begin
    if (vrst) begin
      shift_reg <= IC;
      cpe_q     <= 1'b1;
    end else begin
      cpe_q <= cpe;
      if (!pl_n)
        shift_reg <= d;
      else if (shift_edge)
        shift_reg <= {shift_reg[6:0], ds};
    end
  end

  hc_delay_line #(
    .DELAY(DELAY),
    .INIT (IC[7])
  ) u_q7_delay (
    .clk (clk),
    .rst (vrst),
    .din (shift_reg[7]),
    .dout(q7_dly)
  );

  assign q7   = q7_dly;
  assign q7_n = ~q7_dly;

`ifdef U74HC165_SERIAL_MONITOR_EN
  assign q_par = shift_reg;
`endif

endmodule

// File: tb/tb_u74hc165_piso.sv
// Directed bench for u74hc165_piso (IC=8'hA5, DELAY=9); q_par checks are added
// when U74HC165_SERIAL_MONITOR_EN is defined.
module tb_u74hc165_piso;

  logic       clk = 1'b0;
  logic       rst, vcc, gnd, pl_n, cp, ce_n, ds;
  logic [7:0] d;
  logic       q7, q7_n;
`ifdef U74HC165_SERIAL_MONITOR_EN
  logic [7:0] q_par;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  u74hc165_piso #(
    .IC   (8'hA5),
    .DELAY(9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vcc (vcc),
    .gnd (gnd),
    .pl_n(pl_n),
    .cp  (cp),
    .ce_n(ce_n),
    .ds  (ds),
    .d   (d),
`ifdef U74HC165_SERIAL_MONITOR_EN
    .q_par(q_par),
`endif
    .q7  (q7),
    .q7_n(q7_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_q7(input string tag, input logic exp);
    check_output({tag, "_q7"},  {7'b0, q7},   {7'b0, exp});
    check_output({tag, "_q7n"}, {7'b0, q7_n}, {7'b0, ~exp});
  endtask

  task automatic check_par(input string tag, input logic [7:0] exp);
`ifdef U74HC165_SERIAL_MONITOR_EN
    check_output({tag, "_qpar"}, q_par, exp);
`else
    if (exp === 8'hxx) $display("[TB] note %s", tag);
`endif
  endtask

  // Called just after the edge that changed reg[7]: q7 must hold 8 more cycles, then switch.
  task automatic wait_check(input string tag, input logic old_bit, input logic new_bit);
    repeat (8) tick();
    check_q7({tag, "_hold"}, old_bit);
    tick();
    check_q7({tag, "_new"}, new_bit);
  endtask

  task automatic shift_and_check(input string tag, input logic old_bit, input logic new_bit,
                                 input logic [7:0] par_exp);
    cp = 1'b1;
    tick();
    check_par(tag, par_exp);
    cp = 1'b0;
    wait_check(tag, old_bit, new_bit);
  endtask

  task automatic load(input logic [7:0] value);
    pl_n = 1'b0;
    d    = value;
    tick();
    check_par($sformatf("load_%h", value), value);
    pl_n = 1'b1;
  endtask

  logic       bits_96 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] regs_96 [8] = '{8'h2C, 8'h58, 8'hB0, 8'h60, 8'hC0, 8'h80, 8'h00, 8'h00};
  logic       bits_3c [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] regs_3c [6] = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic       bits_a5 [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] regs_a5 [5] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0};

  initial begin
    logic       old_bit;
    logic [7:0] fill;

    rst  = 1'b1;
    vcc  = 1'b1;
    gnd  = 1'b0;
    pl_n = 1'b1;
    cp   = 1'b0;
    ce_n = 1'b0;
    ds   = 1'b0;
    d    = 8'h00;

    // Reset: register A5, q7 = 1
    tick();
    check_q7("reset0", 1'b1);
    tick();
    check_q7("reset1", 1'b1);
    check_par("reset", 8'hA5);
    rst = 1'b0;
    tick();
    check_q7("reset_after", 1'b1);

    // Load 96, then shift out with ds=0
    load(8'h96);
    repeat (10) tick();
    check_q7("load96", 1'b1);
    old_bit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      shift_and_check($sformatf("shift96_%0d", i), old_bit, bits_96[i], regs_96[i]);
      old_bit = bits_96[i];
    end

    // Fill with ds=1 from 00: only the 8th shift brings a 1 to stage 7, no wrap
    load(8'h00);
    ds = 1'b1;
    repeat (10) tick();
    check_q7("load00", 1'b0);
    old_bit = 1'b0;
    fill    = 8'h00;
    for (int i = 0; i < 9; i++) begin
      fill = {fill[6:0], 1'b1};
      shift_and_check($sformatf("fill_%0d", i), old_bit, (i >= 7), fill);
      old_bit = (i >= 7);
    end

    // Clock inhibit: ce_n changes only while cp=1, cp pulses while inhibited
    ds = 1'b0;
    load(8'hBF);
    repeat (10) tick();
    check_q7("loadBF", 1'b1);
    cp = 1'b1;
    tick();
    check_par("pre_inhibit", 8'h7E);
    ce_n = 1'b1;
    tick();
    cp = 1'b0;
    tick();
    repeat (3) begin
      cp = 1'b1;
      tick();
      cp = 1'b0;
      tick();
    end
    cp = 1'b1;
    tick();
    ce_n = 1'b0;
    tick();
    repeat (10) tick();
    check_q7("inhibit", 1'b0);
    check_par("inhibit", 8'h7E);
    cp = 1'b0;
    tick();
    shift_and_check("after_inhibit", 1'b0, 1'b1, 8'hFC);

    // Load in the same cycle as a cp rising edge: load wins, edge consumed
    pl_n = 1'b0;
    d    = 8'h3C;
    cp   = 1'b1;
    tick();
    check_par("load_3c_edge", 8'h3C);
    pl_n = 1'b1;
    tick();
    check_par("no_extra_shift", 8'h3C);
    repeat (7) tick();
    check_q7("load_3c_hold", 1'b1);
    tick();
    check_q7("load_3c_new", 1'b0);
    cp = 1'b0;
    tick();
    old_bit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      shift_and_check($sformatf("shift3c_%0d", i), old_bit, bits_3c[i], regs_3c[i]);
      old_bit = bits_3c[i];
    end

    // Supply drop mid-shift: reset to A5, cp held high must not shift afterwards
    cp  = 1'b1;
    vcc = 1'b0;
    tick();
    check_q7("vcc_low0", 1'b1);
    tick();
    check_q7("vcc_low1", 1'b1);
    check_par("vcc_low", 8'hA5);
    vcc = 1'b1;
    tick();
    check_q7("vcc_after", 1'b1);
    repeat (10) tick();
    check_q7("no_stale_edge", 1'b1);
    check_par("no_stale_edge", 8'hA5);
    cp = 1'b0;
    tick();
    old_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      shift_and_check($sformatf("shiftA5_%0d", i), old_bit, bits_a5[i], regs_a5[i]);
      old_bit = bits_a5[i];
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
